// File: rtl/pixel_frame_receiver.sv
// Pixel row receiver: assembles two-pixel rows into whole frames in a small
// frame buffer and replays each complete frame as a valid/ready byte stream.
module pixel_frame_receiver #(
  parameter int DATA_W = 8,
  parameter int ROWS   = 2,
  parameter int SLOTS  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              frame_start,
  input  logic              row_valid,
  input  logic [DATA_W-1:0] pixelDataIn1,
  input  logic [DATA_W-1:0] pixelDataIn2,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_first,
  output logic              out_last,
  output logic [15:0]       frame_count,
  output logic [7:0]        drop_count,
  output logic              busy
);

  localparam int BYTES = 2 * ROWS;
  localparam int BW    = $clog2(BYTES);
  localparam int RW    = $clog2(ROWS + 1);
  localparam int SW    = $clog2(SLOTS);

  typedef enum logic [1:0] {C_IDLE, C_CAPTURE, C_DROP} cap_state_t;
  typedef enum logic       {O_IDLE, O_SEND} out_state_t;

  logic [SLOTS-1:0][BYTES-1:0][DATA_W-1:0] slot_data;
  logic [SLOTS-1:0]                        slot_full;
  logic [SLOTS-1:0]                        set_mask, clr_mask;
  logic [SW-1:0]                           wr_ptr, rd_ptr;

  cap_state_t    cap_state, cap_next;
  logic [RW-1:0] row_idx, row_next;
  logic [BW-1:0] wr_addr;
  logic          last_row, wr_en, commit, drop_inc;

  out_state_t    out_state, out_next;
  logic [BW-1:0] byte_idx, byte_next;
  logic          free;

  assign last_row = (row_idx == RW'(ROWS - 1));
  assign wr_addr  = BW'({row_idx, 1'b0});

  // Occupancy decisions look only at pre-edge slot_full, so a slot freed on
  // this edge is not yet visible to a frame_start sampled on the same edge.
  always_comb begin
    cap_next = cap_state;
    row_next = row_idx;
    wr_en    = 1'b0;
    commit   = 1'b0;
    drop_inc = 1'b0;
    if (frame_start) begin
      row_next = '0;
      if (slot_full[wr_ptr]) begin
        cap_next = C_DROP;
        drop_inc = 1'b1;
      end else begin
        cap_next = C_CAPTURE;
        drop_inc = (cap_state == C_CAPTURE);
      end
    end else if (row_valid && cap_state != C_IDLE) begin
      wr_en = (cap_state == C_CAPTURE);
      if (last_row) begin
        row_next = '0;
        cap_next = C_IDLE;
        commit   = (cap_state == C_CAPTURE);
      end else begin
        row_next = row_idx + RW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_state  <= C_IDLE;
      row_idx    <= '0;
      wr_ptr     <= '0;
      drop_count <= '0;
    end else begin
      cap_state <= cap_next;
      row_idx   <= row_next;
      if (commit) wr_ptr <= wr_ptr + SW'(1);
      if (drop_inc && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

  always_comb begin
    out_next  = out_state;
    byte_next = byte_idx;
    free      = 1'b0;
    case (out_state)
      O_IDLE: if (slot_full[rd_ptr]) begin
        out_next  = O_SEND;
        byte_next = '0;
      end
      O_SEND: if (out_ready) begin
        if (byte_idx == BW'(BYTES - 1)) begin
          free      = 1'b1;
          out_next  = O_IDLE;
          byte_next = '0;
        end else begin
          byte_next = byte_idx + BW'(1);
        end
      end
      default: out_next = O_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_state   <= O_IDLE;
      byte_idx    <= '0;
      rd_ptr      <= '0;
      frame_count <= '0;
    end else begin
      out_state <= out_next;
      byte_idx  <= byte_next;
      if (free) begin
        rd_ptr      <= rd_ptr + SW'(1);
        frame_count <= frame_count + 16'd1;
      end
    end
  end

  // Capture always targets a non-full slot and output reads a full one, so
  // set and clear never hit the same slot in one cycle.
  assign set_mask = commit ? (SLOTS'(1) << wr_ptr) : '0;
  assign clr_mask = free   ? (SLOTS'(1) << rd_ptr) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) slot_full <= '0;
    else          slot_full <= (slot_full | set_mask) & ~clr_mask;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      slot_data[wr_ptr][wr_addr]         <= pixelDataIn1;
      slot_data[wr_ptr][wr_addr + BW'(1)] <= pixelDataIn2;
    end
  end

  assign out_valid = (out_state == O_SEND);
  assign out_data  = out_valid ? slot_data[rd_ptr][byte_idx] : '0;
  assign out_first = out_valid && (byte_idx == '0);
  assign out_last  = out_valid && (byte_idx == BW'(BYTES - 1));
  assign busy      = (cap_state != C_IDLE);

endmodule

// File: tb/tb_pixel_frame_receiver.sv
// Bench for pixel_frame_receiver: a vector table for the basic frame, directed
// corner sequences, and a random run against a frame-queue reference model.
module tb_pixel_frame_receiver;

  localparam int ROWS  = 2;
  localparam int SLOTS = 2;
  localparam int BYTES = 2 * ROWS;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_start = 1'b0, row_valid = 1'b0, out_ready = 1'b0;
  logic [7:0]  pix1 = '0, pix2 = '0;
  logic [7:0]  out_data;
  logic        out_valid, out_first, out_last, busy;
  logic [15:0] frame_count;
  logic [7:0]  drop_count;

  pixel_frame_receiver #(.DATA_W(8), .ROWS(ROWS), .SLOTS(SLOTS)) dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .row_valid(row_valid),
    .pixelDataIn1(pix1), .pixelDataIn2(pix2), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_first(out_first), .out_last(out_last),
    .frame_count(frame_count), .drop_count(drop_count), .busy(busy));

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: committed frames wait in a queue; the head is shown from
  // one cycle after its commit and one cycle after the previous frame left.
  typedef struct { logic [BYTES-1:0][7:0] b; int avail; } frm_t;
  frm_t                  q[$];
  logic [BYTES-1:0][7:0] m_cur;
  int                    m_mode, m_rows, m_k, m_next, m_dc, cyc = 0;
  logic [15:0]           m_fc;
  bit                    e_v, e_f, e_l;
  logic [7:0]            e_d;
  logic [7:0]            got[$], want[$];
  bit                    bp_en = 1'b0;
  int                    bp_cnt = 0;

  task automatic m_reset();
    q.delete();
    m_mode = 0; m_rows = 0; m_k = 0; m_next = 0; m_dc = 0; m_fc = '0;
  endtask

  task automatic m_out();
    e_v = 1'b0; e_d = '0; e_f = 1'b0; e_l = 1'b0;
    if (q.size() > 0 && cyc >= q[0].avail && cyc >= m_next) begin
      e_v = 1'b1;
      e_d = q[0].b[m_k];
      e_f = (m_k == 0);
      e_l = (m_k == BYTES - 1);
    end
  endtask

  task automatic m_edge();
    int   sz;
    bit   hs;
    frm_t f;
    m_out();
    hs = e_v && out_ready;
    sz = q.size();
    cyc++;
    if (hs) begin
      if (m_k == BYTES - 1) begin
        q.delete(0); m_k = 0; m_fc++; m_next = cyc + 1;
      end else m_k++;
    end
    if (frame_start) begin
      if (m_mode == 1 && m_dc < 255) m_dc++;
      if (sz >= SLOTS) begin
        m_mode = 2;
        if (m_dc < 255) m_dc++;
      end else m_mode = 1;
      m_rows = 0;
    end else if (row_valid && m_mode != 0) begin
      if (m_mode == 1) begin
        m_cur[2*m_rows] = pix1;
        m_cur[2*m_rows+1] = pix2;
      end
      m_rows++;
      if (m_rows == ROWS) begin
        if (m_mode == 1) begin
          f.b = m_cur; f.avail = cyc + 1;
          q.push_back(f);
        end
        m_mode = 0; m_rows = 0;
      end
    end
  endtask

  task automatic half_check();
    if (bp_en) begin
      out_ready = (bp_cnt % 4 == 0) || (bp_cnt % 4 == 3);
      bp_cnt++;
    end
    @(negedge clk);
    m_out();
    chk("valid", int'(out_valid), int'(e_v));
    if (e_v) begin
      chk("data", int'(out_data), int'(e_d));
      chk("first", int'(out_first), int'(e_f));
      chk("last", int'(out_last), int'(e_l));
    end
    chk("frame_count", int'(frame_count), int'(m_fc));
    chk("drop_count", int'(drop_count), m_dc);
    chk("busy", int'(busy), int'(m_mode != 0));
    if (out_valid && out_ready) got.push_back(out_data);
  endtask

  task automatic edge_go();
    @(posedge clk);
    m_edge();
    #1 frame_start = 1'b0; row_valid = 1'b0;
  endtask

  task automatic tick(); half_check(); edge_go(); endtask
  task automatic idle(input int n); repeat (n) tick(); endtask

  task automatic send_frame(input logic [7:0] a, b, c, d);
    frame_start = 1'b1; tick();
    row_valid = 1'b1; pix1 = a; pix2 = b; tick();
    row_valid = 1'b1; pix1 = c; pix2 = d; tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0; frame_start = 1'b0; row_valid = 1'b0; bp_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    m_reset();
    got.delete();
  endtask

  task automatic chk_got(input string nm);
    chk({nm, "_len"}, got.size(), want.size());
    for (int i = 0; i < want.size() && i < got.size(); i++)
      chk($sformatf("%s_b%0d", nm, i), int'(got[i]), int'(want[i]));
  endtask

  typedef struct {
    logic fs, rv; logic [7:0] a, b;
    logic ev; logic [7:0] ed; logic ef, el, eb; logic [15:0] efc;
  } vec_t;
  vec_t tbl[9];

  initial begin
    bit found;
    tbl[0] = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[1] = '{1'b0, 1'b1, 8'h11, 8'h22, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'd0};
    tbl[2] = '{1'b0, 1'b1, 8'h33, 8'h44, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'd0};
    tbl[3] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[4] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[5] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[6] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[7] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h44, 1'b0, 1'b1, 1'b0, 16'd0};
    tbl[8] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd1};

    // Reset state while reset is held
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_first", int'(out_first), 0);
    chk("rst_last", int'(out_last), 0);
    chk("rst_fc", int'(frame_count), 0);
    chk("rst_dc", int'(drop_count), 0);
    chk("rst_busy", int'(busy), 0);

    // Single frame from the vector table
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      frame_start = tbl[i].fs; row_valid = tbl[i].rv; pix1 = tbl[i].a; pix2 = tbl[i].b;
      half_check();
      chk($sformatf("tbl%0d_valid", i), int'(out_valid), int'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_data", i), int'(out_data), int'(tbl[i].ed));
        chk($sformatf("tbl%0d_first", i), int'(out_first), int'(tbl[i].ef));
        chk($sformatf("tbl%0d_last", i), int'(out_last), int'(tbl[i].el));
      end
      chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].eb));
      chk($sformatf("tbl%0d_fc", i), int'(frame_count), int'(tbl[i].efc));
      edge_go();
    end

    // Backpressure 1,0,0,1 over two frames
    do_reset();
    bp_en = 1'b1; bp_cnt = 0;
    send_frame(8'h01, 8'h02, 8'h03, 8'h04);
    send_frame(8'h05, 8'h06, 8'h07, 8'h08);
    idle(30);
    bp_en = 1'b0;
    want = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    chk_got("bp");
    chk("bp_fc", int'(frame_count), 2);

    // Buffer full: third frame dropped
    do_reset();
    out_ready = 1'b0;
    send_frame(8'h10, 8'h11, 8'h12, 8'h13);
    send_frame(8'h20, 8'h21, 8'h22, 8'h23);
    send_frame(8'h30, 8'h31, 8'h32, 8'h33);
    idle(2);
    chk("full_dc", int'(drop_count), 1);
    chk("full_fc0", int'(frame_count), 0);
    out_ready = 1'b1;
    idle(14);
    chk("full_fc", int'(frame_count), 2);
    want = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22, 8'h23};
    chk_got("full");

    // Truncated frame is discarded
    do_reset();
    out_ready = 1'b1;
    frame_start = 1'b1; tick();
    row_valid = 1'b1; pix1 = 8'h55; pix2 = 8'h66; tick();
    send_frame(8'hA0, 8'hA1, 8'hA2, 8'hA3);
    idle(8);
    chk("trunc_dc", int'(drop_count), 1);
    chk("trunc_fc", int'(frame_count), 1);
    want = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    chk_got("trunc");

    // frame_start on the freeing handshake is dropped; one cycle later accepted
    do_reset();
    out_ready = 1'b0;
    send_frame(8'h41, 8'h42, 8'h43, 8'h44);
    send_frame(8'h51, 8'h52, 8'h53, 8'h54);
    idle(2);
    out_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      m_out();
      if (e_v && e_l) found = 1'b1;
      else tick();
    end
    chk("simul_wait", int'(found), 1);
    frame_start = 1'b1; tick();
    chk("simul_drop", int'(drop_count), 1);
    chk("simul_busy", int'(busy), 1);
    frame_start = 1'b1; tick();
    row_valid = 1'b1; pix1 = 8'h61; pix2 = 8'h62; tick();
    row_valid = 1'b1; pix1 = 8'h63; pix2 = 8'h64; tick();
    idle(12);
    chk("simul_dc", int'(drop_count), 1);
    chk("simul_fc", int'(frame_count), 3);
    want = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h51, 8'h52, 8'h53, 8'h54,
             8'h61, 8'h62, 8'h63, 8'h64};
    chk_got("simul");

    // drop_count saturation
    do_reset();
    out_ready = 1'b0;
    send_frame(8'h71, 8'h72, 8'h73, 8'h74);
    send_frame(8'h81, 8'h82, 8'h83, 8'h84);
    for (int i = 0; i < 260; i++) begin
      frame_start = 1'b1; tick();
    end
    chk("sat_dc", int'(drop_count), 255);
    out_ready = 1'b1;
    idle(14);
    chk("sat_fc", int'(frame_count), 2);

    // Async reset mid-SEND
    do_reset();
    out_ready = 1'b0;
    frame_start = 1'b1; tick();
    send_frame(8'hC1, 8'hC2, 8'hC3, 8'hC4);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      m_out();
      if (e_v) found = 1'b1;
      else tick();
    end
    chk("ars_wait", int'(found), 1);
    chk("ars_pre_dc", int'(drop_count), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("ars_valid", int'(out_valid), 0);
    chk("ars_data", int'(out_data), 0);
    chk("ars_first", int'(out_first), 0);
    chk("ars_last", int'(out_last), 0);
    chk("ars_fc", int'(frame_count), 0);
    chk("ars_dc", int'(drop_count), 0);
    chk("ars_busy", int'(busy), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    m_reset();
    got.delete();
    out_ready = 1'b1;
    send_frame(8'hD1, 8'hD2, 8'hD3, 8'hD4);
    idle(8);
    chk("ars_after_fc", int'(frame_count), 1);
    want = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};
    chk_got("ars_after");

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit fs;
      fs = ($urandom_range(0, 11) == 0);
      frame_start = fs;
      row_valid = !fs && ($urandom_range(0, 2) == 0);
      pix1 = 8'($urandom);
      pix2 = 8'($urandom);
      out_ready = ((i / 200) % 3 == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
